// File: rtl/uart_report_pkg.sv
// Shared definitions for the UART telemetry report scheduler.
package uart_report_pkg;

  // Frame sequencer states; IDLE is the only state that does not push.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_ID,
    ST_DATA,
    ST_CHK
  } state_e;

  // Display mode selector encoding.
  typedef enum logic [1:0] {
    MODE_WATCH = 2'b00,
    MODE_SW    = 2'b01,
    MODE_SR    = 2'b10,
    MODE_DHT   = 2'b11
  } mode_e;

  // Requester indices.
  localparam logic [1:0] SRC_TIME = 2'd0;
  localparam logic [1:0] SRC_SW   = 2'd1;
  localparam logic [1:0] SRC_SR   = 2'd2;
  localparam logic [1:0] SRC_DHT  = 2'd3;

  localparam logic [7:0]  SOF_BYTE_DEF   = 8'hA5;
  localparam int unsigned PERIOD_CYC_DEF = 100_000_000;

  // Frame ID byte for a source: ID = source index + 1.
  function automatic logic [7:0] src_id(input logic [1:0] src);
    return {6'b0, src} + 8'd1;
  endfunction

endpackage

// File: rtl/uart_report_sched_rr_arb4.sv
// Four-way round-robin arbiter: searches from last+1 upward, wrapping.
module rr_arb4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [3:0] gnt_o,
  output logic [1:0] idx_o,
  output logic       valid_o
);

  logic [1:0] cand;

  // First requesting source after the last winner, modulo 4.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned off = 1; off <= 4; off++) begin
      cand = last_i + 2'(off);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_report_sched.sv
// Telemetry report scheduler: captures requests from four sources and
// emits one SOF/ID/DATA/CHK frame per grant into the UART TX FIFO.
module uart_report_sched
  import uart_report_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE   = SOF_BYTE_DEF,
  parameter int unsigned PERIOD_CYC = PERIOD_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode_sel,
  input  logic [7:0] time_data,
  input  logic [7:0] sw_data,
  input  logic [7:0] sr_data,
  input  logic [7:0] dht_data,
  input  logic       sr_done,
  input  logic       dht_done,
  input  logic       fifo_full,
  output logic       push,
  output logic [7:0] push_data,
  output logic       busy,
  output logic [3:0] grant,
  output logic [7:0] drop_cnt
);

  localparam int unsigned   CW       = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [CW-1:0] TICK_VAL = CW'(PERIOD_CYC - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   per_cnt_q, per_cnt_d;
  logic            tick;
  logic [3:0]      req;
  logic [3:0][7:0] req_data;
  logic [3:0]      pend_q, pend_d;
  logic [3:0][7:0] snap_q, snap_d;
  logic [3:0]      drop;
  logic [2:0]      ndrop;
  logic [8:0]      drop_sum;
  logic [7:0]      drop_q, drop_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [3:0]      grant_q, grant_d;
  logic [7:0]      frame_id_q, frame_id_d;
  logic [7:0]      frame_data_q, frame_data_d;
  logic [3:0]      arb_gnt;
  logic [1:0]      arb_idx;
  logic            arb_valid;
  logic            do_grant;

  rr_arb4 u_arb (
    .req_i   (pend_q),
    .last_i  (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Free-running period counter; tick on its last count.
  always_comb begin
    tick      = (per_cnt_q == TICK_VAL);
    per_cnt_d = tick ? '0 : per_cnt_q + CW'(1);
  end

  // Request decode: periodic reports follow mode_sel, done pulses do not.
  always_comb begin
    req                = '0;
    req[SRC_TIME]      = tick && (mode_sel == MODE_WATCH);
    req[SRC_SW]        = tick && (mode_sel == MODE_SW);
    req[SRC_SR]        = sr_done;
    req[SRC_DHT]       = dht_done;
    req_data           = '0;
    req_data[SRC_TIME] = time_data;
    req_data[SRC_SW]   = sw_data;
    req_data[SRC_SR]   = sr_data;
    req_data[SRC_DHT]  = dht_data;
  end

  assign do_grant = (state_q == ST_IDLE) && arb_valid;

  // Pending/snapshot update; a request in the grant cycle re-arms the
  // source, and it only counts as a drop when the old request is not
  // being served that same cycle.
  always_comb begin
    pend_d = pend_q;
    snap_d = snap_q;
    drop   = '0;
    ndrop  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      pend_d[i] = req[i] | (pend_q[i] & ~(do_grant & arb_gnt[i]));
      drop[i]   = req[i] & pend_q[i] & ~(do_grant & arb_gnt[i]);
      if (req[i]) snap_d[i] = req_data[i];
      ndrop = ndrop + {2'b0, drop[i]};
    end
    drop_sum = {1'b0, drop_q} + {6'b0, ndrop};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Frame FSM: next state, frame capture and FIFO push outputs.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    frame_id_d   = frame_id_q;
    frame_data_d = frame_data_q;
    rr_ptr_d     = rr_ptr_q;
    push         = 1'b0;
    push_data    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (do_grant) begin
          state_d      = ST_SOF;
          grant_d      = arb_gnt;
          frame_id_d   = src_id(arb_idx);
          frame_data_d = snap_q[arb_idx];
          rr_ptr_d     = arb_idx;
        end
      end
      ST_SOF: begin
        push      = !fifo_full;
        push_data = SOF_BYTE;
        if (push) state_d = ST_ID;
      end
      ST_ID: begin
        push      = !fifo_full;
        push_data = frame_id_q;
        if (push) state_d = ST_DATA;
      end
      ST_DATA: begin
        push      = !fifo_full;
        push_data = frame_data_q;
        if (push) state_d = ST_CHK;
      end
      ST_CHK: begin
        push      = !fifo_full;
        push_data = frame_id_q ^ frame_data_q;
        if (push) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset points the arbiter at source 3 so source 0 is searched first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      per_cnt_q    <= '0;
      pend_q       <= '0;
      snap_q       <= '0;
      drop_q       <= '0;
      rr_ptr_q     <= SRC_DHT;
      grant_q      <= '0;
      frame_id_q   <= '0;
      frame_data_q <= '0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      pend_q       <= pend_d;
      snap_q       <= snap_d;
      drop_q       <= drop_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      frame_id_q   <= frame_id_d;
      frame_data_q <= frame_data_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign grant    = grant_q;
  assign drop_cnt = drop_q;

endmodule
